// File: rtl/cordic_sched_pkg.sv
// Shared types and width helpers for the CORDIC round-robin scheduler.
// Provides the FSM state encoding and helper functions that size the owner index
// and the cycle counters from the module parameters.
package cordic_sched_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StGrant   = 3'd1,
    StLaunch  = 3'd2,
    StWait    = 3'd3,
    StDeliver = 3'd4,
    StGuard   = 3'd5
  } state_e;

  // Width of an index selecting one of n requesters (OWNER_W).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must hold max_val (TO_W for TIMEOUT).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cordic_rr_scheduler_if.sv
// Handshake bundle between the scheduler and the shared CORDIC unit.
//   beg_FSM_CORDIC  start strobe to the CORDIC
//   operation       0 = cosine, 1 = sine
//   data_in         angle to the CORDIC
//   ready_CORDIC    CORDIC result valid
//   data_output     CORDIC result
//   ACK_FSM_CORDIC  result-consumed acknowledge
// master: scheduler side; slave: CORDIC side.
interface cordic_rr_scheduler_if #(
  parameter int unsigned W = 32
);
  logic         beg_FSM_CORDIC;
  logic         operation;
  logic [W-1:0] data_in;
  logic         ready_CORDIC;
  logic [W-1:0] data_output;
  logic         ACK_FSM_CORDIC;

  modport master (
    output beg_FSM_CORDIC,
    output operation,
    output data_in,
    output ACK_FSM_CORDIC,
    input  ready_CORDIC,
    input  data_output
  );

  modport slave (
    input  beg_FSM_CORDIC,
    input  operation,
    input  data_in,
    input  ACK_FSM_CORDIC,
    output ready_CORDIC,
    output data_output
  );
endinterface

// File: rtl/cordic_rr_scheduler_rr_pick.sv
// Combinational round-robin picker.
//   req_i      request vector
//   ptr_i      index of the last granted requester
//   grant_o    first active index searching cyclically from ptr_i + 1
//   any_req_o  at least one request is active
module cordic_rr_scheduler_rr_pick
  import cordic_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned OwnerW = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0]  req_i,
  input  logic [OwnerW-1:0] ptr_i,
  output logic [OwnerW-1:0] grant_o,
  output logic              any_req_o
);
  localparam int NReqI = int'(N_REQ);

  logic [OwnerW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest active one wins.
  always_comb begin
    grant_o = '0;
    idx     = '0;
    for (int i = NReqI; i > 0; i--) begin
      idx = OwnerW'((int'(ptr_i) + i) % NReqI);
      if (req_i[idx]) grant_o = idx;
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one CORDIC sine/cosine unit among N_REQ requesters, round-robin.
//   clk, reset_n        clock, asynchronous active-low reset
//   req/req_op/req_data per-requester request level, operation and angle
//   done/result         one-cycle done pulse to the owner, shared result bus
//   timeout_err         sticky flag set when a CORDIC job is aborted
//   busy                high from grant until the post-ack guard has elapsed
//   cordic              start/ack handshake to the CORDIC (master side)
module cordic_rr_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned GUARD   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_op,
  input  logic [N_REQ*W-1:0]    req_data,
  output logic [N_REQ-1:0]      done,
  output logic [W-1:0]          result,
  output logic                  timeout_err,
  output logic                  busy,
  cordic_rr_scheduler_if.master cordic
);
  localparam int unsigned OwnerW = idx_w(N_REQ);
  localparam int unsigned ToW    = cnt_w(TIMEOUT);
  localparam int unsigned GuardW = cnt_w(GUARD);

  state_e            state_q, state_d;
  logic [OwnerW-1:0] owner_q, owner_d;
  logic [OwnerW-1:0] ptr_q, ptr_d;
  logic              op_q, op_d;
  logic [W-1:0]      data_q, data_d;
  logic [W-1:0]      result_q, result_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic [GuardW-1:0] guard_q, guard_d;
  logic              launch_q, launch_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              beg, ack;
  logic [OwnerW-1:0] grant;
  logic              any_req;
  logic [W-1:0]      angle [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_angle
    assign angle[k] = req_data[k*W +: W];
  end

  cordic_rr_scheduler_rr_pick #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .grant_o  (grant),
    .any_req_o(any_req)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    op_d     = op_q;
    data_d   = data_q;
    result_d = result_q;
    to_cnt_d = to_cnt_q;
    guard_d  = guard_q;
    launch_d = launch_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done     = '0;
    beg      = 1'b0;
    ack      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StGrant;
          busy_d  = 1'b1;
        end
      end
      StGrant: begin
        // req is not latched: if it vanished since IDLE, nothing is served.
        if (any_req) begin
          owner_d  = grant;
          ptr_d    = grant;
          op_d     = req_op[grant];
          data_d   = angle[grant];
          launch_d = 1'b0;
          state_d  = StLaunch;
        end else begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StLaunch: begin
        // Two-cycle start lets the CORDIC pass through its reset-to-idle step.
        beg      = 1'b1;
        to_cnt_d = '0;
        if (launch_q) state_d = StWait;
        else          launch_d = 1'b1;
      end
      StWait: begin
        to_cnt_d = to_cnt_q + ToW'(1);
        if (cordic.ready_CORDIC) begin
          result_d = cordic.data_output;
          state_d  = StDeliver;
        end else if (to_cnt_q == ToW'(TIMEOUT)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = StDeliver;
        end
      end
      StDeliver: begin
        done[owner_q] = 1'b1;
        ack           = 1'b1;
        guard_d       = GuardW'(GUARD);
        state_d       = StGuard;
      end
      StGuard: begin
        if (guard_q <= GuardW'(1)) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          guard_d = guard_q - GuardW'(1);
        end
      end
      default: state_d = StGuard;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StGuard;
      owner_q  <= '0;
      ptr_q    <= OwnerW'(N_REQ - 1);
      op_q     <= 1'b0;
      data_q   <= '0;
      result_q <= '0;
      to_cnt_q <= '0;
      guard_q  <= GuardW'(GUARD);
      launch_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      op_q     <= op_d;
      data_q   <= data_d;
      result_q <= result_d;
      to_cnt_q <= to_cnt_d;
      guard_q  <= guard_d;
      launch_q <= launch_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign result                = result_q;
  assign timeout_err           = err_q;
  assign busy                  = busy_q;
  assign cordic.beg_FSM_CORDIC = beg;
  assign cordic.operation      = op_q;
  assign cordic.data_in        = data_q;
  assign cordic.ACK_FSM_CORDIC = ack;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Directed bench for cordic_rr_scheduler: instance A (default TIMEOUT) with a
// latency-programmable CORDIC model, instance B (TIMEOUT=15) with ready driven by hand.
module tb_cordic_rr_scheduler;

  logic clk;
  logic reset_n;

  logic [3:0]   a_req, a_op, a_done;
  logic [127:0] a_data;
  logic [31:0]  a_result;
  logic         a_err, a_busy;

  logic [3:0]   b_req, b_op, b_done;
  logic [127:0] b_data;
  logic [31:0]  b_result;
  logic         b_err, b_busy;

  cordic_rr_scheduler_if #(.W(32)) a_if ();
  cordic_rr_scheduler_if #(.W(32)) b_if ();

  cordic_rr_scheduler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (a_req),
    .req_op     (a_op),
    .req_data   (a_data),
    .done       (a_done),
    .result     (a_result),
    .timeout_err(a_err),
    .busy       (a_busy),
    .cordic     (a_if)
  );

  cordic_rr_scheduler #(.TIMEOUT(15)) dut_to (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (b_req),
    .req_op     (b_op),
    .req_data   (b_data),
    .done       (b_done),
    .result     (b_result),
    .timeout_err(b_err),
    .busy       (b_busy),
    .cordic     (b_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CORDIC model for instance A: pi/4 yields sin=cos=0x3F3504F3, other angles
  // yield angle+0x100 (sine) or angle+0x200 (cosine).
  int          model_lat = 40;
  logic        m_busy;
  int          m_cnt;

  function automatic logic [31:0] model_f(input logic [31:0] ang, input logic op);
    if (ang == 32'h3F490FDB) return 32'h3F3504F3;
    return op ? ang + 32'h100 : ang + 32'h200;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy               <= 1'b0;
      m_cnt                <= 0;
      a_if.ready_CORDIC    <= 1'b0;
      a_if.data_output     <= '0;
    end else if (a_if.ACK_FSM_CORDIC) begin
      m_busy               <= 1'b0;
      a_if.ready_CORDIC    <= 1'b0;
    end else if (!m_busy && a_if.beg_FSM_CORDIC) begin
      m_busy               <= 1'b1;
      m_cnt                <= model_lat;
    end else if (m_busy && !a_if.ready_CORDIC) begin
      if (m_cnt <= 1) begin
        a_if.ready_CORDIC  <= 1'b1;
        a_if.data_output   <= model_f(a_if.data_in, a_if.operation);
      end else begin
        m_cnt              <= m_cnt - 1;
      end
    end
  end

  // Event counters for instance A, sampled on the falling edge.
  int beg_cnt  = 0;
  int ack_cnt  = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (a_if.beg_FSM_CORDIC) beg_cnt <= beg_cnt + 1;
    if (a_if.ACK_FSM_CORDIC) ack_cnt <= ack_cnt + 1;
    if (a_done != 4'b0)      done_cnt <= done_cnt + 1;
  end

  task automatic wait_a_done();
    int c = 0;
    while (a_done == 4'b0 && c < 300) begin @(negedge clk); c++; end
  endtask

  task automatic wait_a_wait_entry();
    int c = 0;
    while (!a_if.beg_FSM_CORDIC && c < 100) begin @(negedge clk); c++; end
    while (a_if.beg_FSM_CORDIC && c < 100) begin @(negedge clk); c++; end
  endtask

  task automatic wait_b_wait_entry();
    int c = 0;
    while (!b_if.beg_FSM_CORDIC && c < 100) begin @(negedge clk); c++; end
    while (b_if.beg_FSM_CORDIC && c < 100) begin @(negedge clk); c++; end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    n_checks++;
    if ({a_done, a_err, a_busy, a_if.beg_FSM_CORDIC, a_if.operation, a_if.ACK_FSM_CORDIC} !== 9'b0)
      $display("FAIL reset_ctrl got %b exp 0", {a_done, a_err, a_busy, a_if.beg_FSM_CORDIC,
               a_if.operation, a_if.ACK_FSM_CORDIC});
    else n_pass++;
    n_checks++;
    if (a_result !== 32'h0 || a_if.data_in !== 32'h0)
      $display("FAIL reset_data got result=%h data_in=%h exp 0", a_result, a_if.data_in);
    else n_pass++;
    n_checks++;
    if ({b_done, b_err, b_busy, b_if.beg_FSM_CORDIC} !== 7'b0)
      $display("FAIL reset_b got %b exp 0", {b_done, b_err, b_busy, b_if.beg_FSM_CORDIC});
    else n_pass++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (a_busy !== 1'b0 || a_if.beg_FSM_CORDIC !== 1'b0)
      $display("FAIL reset_idle got busy=%b beg=%b exp 0 0", a_busy, a_if.beg_FSM_CORDIC);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_res [4];
    exp_res = '{32'h3F3504F3, 32'h11110200, 32'h22220100, 32'h33330200};
    model_lat = 5;
    a_op   = 4'b0101;
    a_data = {32'h33330000, 32'h22220000, 32'h11110000, 32'h3F490FDB};
    a_req  = 4'hF;
    for (int t = 0; t < 8; t++) begin
      wait_a_done();
      n_checks++;
      if (a_done !== (4'b0001 << (t % 4)))
        $display("FAIL rr_grant_%0d got %b exp %b", t, a_done, 4'b0001 << (t % 4));
      else n_pass++;
      n_checks++;
      if (a_result !== exp_res[t % 4])
        $display("FAIL rr_result_%0d got %h exp %h", t, a_result, exp_res[t % 4]);
      else n_pass++;
      if (t == 7) a_req = 4'h0;
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_single();
    int beg0, ack0, done0;
    beg0  = beg_cnt;
    ack0  = ack_cnt;
    done0 = done_cnt;
    model_lat = 40;
    a_op  = 4'b0001;
    a_req = 4'b0001;
    wait_a_wait_entry();
    repeat (3) @(negedge clk);
    n_checks++;
    if (a_if.operation !== 1'b1 || a_if.data_in !== 32'h3F490FDB || a_busy !== 1'b1)
      $display("FAIL single_wait got op=%b data_in=%h busy=%b exp 1 3f490fdb 1",
               a_if.operation, a_if.data_in, a_busy);
    else n_pass++;
    wait_a_done();
    n_checks++;
    if (a_done !== 4'b0001 || a_result !== 32'h3F3504F3)
      $display("FAIL single_done got done=%b result=%h exp 0001 3f3504f3", a_done, a_result);
    else n_pass++;
    a_req = 4'b0;
    @(negedge clk);
    n_checks++;
    if (a_done !== 4'b0)
      $display("FAIL single_pulse got %b exp 0000", a_done);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if (beg_cnt - beg0 != 2 || ack_cnt - ack0 != 1 || done_cnt - done0 != 1)
      $display("FAIL single_counts got beg=%0d ack=%0d done=%0d exp 2 1 1",
               beg_cnt - beg0, ack_cnt - ack0, done_cnt - done0);
    else n_pass++;
    n_checks++;
    if (a_busy !== 1'b0)
      $display("FAIL single_busy_end got %b exp 0", a_busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int c;
    model_lat = 10;
    a_op  = 4'b0100;
    a_req = 4'b0010;
    wait_a_wait_entry();
    repeat (2) @(negedge clk);
    a_req[2] = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (a_if.data_in !== 32'h11110000)
      $display("FAIL b2b_data_hold got %h exp 11110000", a_if.data_in);
    else n_pass++;
    wait_a_done();
    n_checks++;
    if (a_done !== 4'b0010 || a_result !== 32'h11110200)
      $display("FAIL b2b_first got done=%b result=%h exp 0010 11110200", a_done, a_result);
    else n_pass++;
    a_req[1] = 1'b0;
    c = 0;
    while (!a_if.beg_FSM_CORDIC && c < 50) begin @(negedge clk); c++; end
    n_checks++;
    if (c != 5)
      $display("FAIL b2b_turnaround got %0d cycles exp 5", c);
    else n_pass++;
    n_checks++;
    if (a_if.data_in !== 32'h22220000 || a_if.operation !== 1'b1)
      $display("FAIL b2b_launch got data_in=%h op=%b exp 22220000 1", a_if.data_in,
               a_if.operation);
    else n_pass++;
    wait_a_done();
    n_checks++;
    if (a_done !== 4'b0100 || a_result !== 32'h22220100)
      $display("FAIL b2b_second got done=%b result=%h exp 0100 22220100", a_done, a_result);
    else n_pass++;
    a_req = 4'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_ready_boundary();
    b_op   = 4'b0100;
    b_data = {32'h0, 32'h5A5A0000, 32'h0, 32'h0};
    b_req  = 4'b0100;
    wait_b_wait_entry();
    repeat (15) @(negedge clk);
    b_if.ready_CORDIC = 1'b1;
    b_if.data_output  = 32'h12345678;
    @(negedge clk);
    n_checks++;
    if (b_done !== 4'b0100 || b_result !== 32'h12345678)
      $display("FAIL boundary_done got done=%b result=%h exp 0100 12345678", b_done, b_result);
    else n_pass++;
    n_checks++;
    if (b_err !== 1'b0)
      $display("FAIL boundary_err got %b exp 0", b_err);
    else n_pass++;
    b_if.ready_CORDIC = 1'b0;
    b_req = 4'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_timeout();
    int c;
    b_op   = 4'b0000;
    b_data = {32'h0, 32'h0, 32'h77770000, 32'h0};
    b_req  = 4'b0010;
    wait_b_wait_entry();
    c = 0;
    while (b_done == 4'b0 && c < 40) begin @(negedge clk); c++; end
    n_checks++;
    if (c != 16)
      $display("FAIL timeout_latency got %0d cycles exp 16", c);
    else n_pass++;
    n_checks++;
    if (b_done !== 4'b0010 || b_result !== 32'h0 || b_err !== 1'b1)
      $display("FAIL timeout_done got done=%b result=%h err=%b exp 0010 0 1", b_done, b_result,
               b_err);
    else n_pass++;
    b_req = 4'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (b_err !== 1'b1)
      $display("FAIL timeout_sticky got %b exp 1", b_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int done0;
    model_lat = 40;
    a_op  = 4'b0000;
    a_req = 4'b0001;
    wait_a_wait_entry();
    repeat (3) @(negedge clk);
    done0 = done_cnt;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({a_done, a_busy, a_if.beg_FSM_CORDIC, a_if.ACK_FSM_CORDIC, a_if.operation} !== 8'b0
        || a_result !== 32'h0 || a_if.data_in !== 32'h0)
      $display("FAIL midreset_async got done=%b busy=%b result=%h data_in=%h exp 0", a_done,
               a_busy, a_result, a_if.data_in);
    else n_pass++;
    n_checks++;
    if (b_err !== 1'b0)
      $display("FAIL midreset_err_clear got %b exp 0", b_err);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    a_req   = 4'b0011;
    repeat (2) @(negedge clk);
    n_checks++;
    if (done_cnt != done0)
      $display("FAIL midreset_no_done got %0d extra exp 0", done_cnt - done0);
    else n_pass++;
    wait_a_done();
    n_checks++;
    if (a_done !== 4'b0001 || a_result !== 32'h3F3504F3)
      $display("FAIL midreset_first got done=%b result=%h exp 0001 3f3504f3", a_done, a_result);
    else n_pass++;
    a_req[0] = 1'b0;
    @(negedge clk);
    wait_a_done();
    n_checks++;
    if (a_done !== 4'b0010 || a_result !== 32'h11110200)
      $display("FAIL midreset_second got done=%b result=%h exp 0010 11110200", a_done, a_result);
    else n_pass++;
    a_req = 4'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset_n           = 1'b1;
    a_req             = 4'b0;
    a_op              = 4'b0;
    a_data            = '0;
    b_req             = 4'b0;
    b_op              = 4'b0;
    b_data            = '0;
    b_if.ready_CORDIC = 1'b0;
    b_if.data_output  = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_back_to_back();
    test_ready_boundary();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cordic_rr_scheduler.md
Name: cordic_rr_scheduler

Overview:
- Shares one CORDIC sine/cosine unit among N_REQ requesters using round-robin arbitration.
- Latches the granted requester's angle and operation, drives the CORDIC start/acknowledge handshake, and captures the result.
- Returns the result to the owning requester with a one-cycle done pulse.
- Sits between the CORDIC top level and the client blocks, such as waveform generators and rotation engines.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 32, angle/result width (single-precision word).
- TIMEOUT, 1023, maximum cycles allowed in WAIT before abort.
- GUARD, 2, idle cycles enforced after ACK_FSM_CORDIC before the next launch.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level.
- req_op  in  N_REQ  per-requester operation: 0 = cosine, 1 = sine.
- req_data  in  N_REQ*W  per-requester angle; slice k occupies [k*W +: W].
- done  out  N_REQ  one-cycle pulse to the owning requester.
- result  out  W  shared result bus, valid while done[k]=1.
- timeout_err  out  1  sticky abort flag.
- busy  out  1  high from GRANT through GUARD.
- beg_FSM_CORDIC  out  1  CORDIC start.
- operation  out  1  operation select to CORDIC.
- data_in  out  W  angle to CORDIC.
- ready_CORDIC  in  1  CORDIC result valid.
- data_output  in  W  CORDIC result.
- ACK_FSM_CORDIC  out  1  result-consumed acknowledge to CORDIC.

Behaviour:
- Reset values: all outputs 0; state=GUARD with guard counter=GUARD; rr pointer=N_REQ-1, so requester 0 has first priority.
- Requester protocol:
  - Requester raises req[k] and holds req_op[k]/req_data[k] stable until done[k].
  - Requester must drop req[k] the cycle after done[k]. A req still high then is treated as a new request.
- State machine:
  - IDLE: if any req, go to GRANT. Otherwise stay.
  - GRANT:
    - Choose the first active k searching from pointer+1 cyclically.
    - Register owner=k, operation=req_op[k], data_in=req_data[k]; pointer=k.
    - Go to LAUNCH.
  - LAUNCH: beg_FSM_CORDIC=1 for exactly 2 consecutive cycles (launch counter). This covers the CORDIC's one-cycle reset-to-idle step. Then go to WAIT.
  - WAIT:
    - Increment timeout counter; keep operation and data_in stable.
    - If ready_CORDIC=1: capture data_output into result, go to DELIVER.
    - Else if counter==TIMEOUT: result=0, timeout_err=1, go to DELIVER.
  - DELIVER: done[owner]=1 for one cycle; ACK_FSM_CORDIC=1 in the same cycle. Go to GUARD.
  - GUARD: count GUARD cycles with all CORDIC outputs low, then go to IDLE.
- Latency: GRANT to first beg = 1 cycle; ready_CORDIC to done = 1 cycle.
- Minimum turnaround: 3 + GUARD cycles plus CORDIC latency.
- Simultaneous events:
  - Requests arriving during busy wait; none is dropped.
  - A req that deasserts before GRANT is not served; there is no latching of req.
  - ready_CORDIC on the same cycle the counter hits TIMEOUT counts as ready (no error).
- Reset mid-operation: all state is abandoned; no done is issued. The CORDIC must share the same reset tree.
- Fairness: with every req held high, grants rotate 0,1,...,N_REQ-1,0.
- timeout_err clears only on reset.

Decomposition:
- Package cordic_sched_pkg:
  - state encoding: IDLE, GRANT, LAUNCH, WAIT, DELIVER, GUARD, as 3-bit localparams.
  - OWNER_W = clog2(N_REQ).
  - TO_W = clog2(TIMEOUT+1).
- Sub-module rr_pick, combinational:
  - inputs: req vector, pointer.
  - outputs: grant index, any_req.
  - Parameterised by N_REQ; reused by other shared-unit schedulers.

Test Plan:
- Single request: req[0]=1, req_op[0]=1, angle 0x3F490FDB (pi/4); CORDIC model returns 0x3F3504F3 after 40 cycles.
  - Expect: beg high 2 cycles, operation=1, done[0] pulse with result=0x3F3504F3, one ACK pulse.
- All four requesters held high for 8 transactions:
  - Expect: grant order 0,1,2,3,0,1,2,3; no done on a non-owner; result matches each requester's angle.
- Back-to-back contention: req[2] rises while req[1] is in WAIT.
  - Expect: req[2] served next, beg not asserted during GUARD, data_in switches only in GRANT.
- Timeout: model never raises ready_CORDIC, TIMEOUT=15.
  - Expect: done[owner] 16 cycles after WAIT entry, result=0, timeout_err=1 and sticky.
- Reset mid-WAIT: reset_n low for 1 cycle.
  - Expect: all outputs 0 asynchronously; no done pulse; first grant afterwards goes to requester 0.
- Ready on the timeout boundary: ready_CORDIC coincides with counter==TIMEOUT.
  - Expect: result captured, timeout_err stays 0.
